// File: rtl/norm_pkg.sv
// Shared constants and width helper for the fixed-point normaliser pipeline.
// The helper sizes the intermediate value so that shifting and rounding never wrap.
package norm_pkg;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_HALF_UP = 1;
   localparam int SAT_WRAP      = 0;
   localparam int SAT_CLAMP     = 1;

   // One guard bit for the rounding add plus any left-shift growth; never narrower than the output.
   function automatic int norm_iw(input int a_width, input int a_scale,
                                  input int f_width, input int f_scale);
      int w;
      w = a_width + 1 + ((f_scale > a_scale) ? (f_scale - a_scale) : 0);
      return (w > f_width) ? w : f_width;
   endfunction

endpackage

// File: rtl/norm_round.sv
// Combinational rescale of a signed sample: shift, optional half-up rounding, and
// a range check of the full-precision result against the output format.
module norm_round
   import norm_pkg::*;
#(
   parameter int A_WIDTH = 32,
   parameter int A_SCALE = 12,
   parameter int F_WIDTH = 32,
   parameter int F_SCALE = 12,
   parameter int ROUND   = ROUND_HALF_UP,
   parameter int IW      = norm_iw(A_WIDTH, A_SCALE, F_WIDTH, F_SCALE)
) (
   input  logic [A_WIDTH-1:0] a,
   output logic [IW-1:0]      x,
   output logic               ovf
);

   // 0: widen (left shift), 1: narrow with rounding, 2: narrow with floor
   localparam int MODE = (F_SCALE >= A_SCALE) ? 0 : ((ROUND == ROUND_HALF_UP) ? 1 : 2);
   localparam int SH   = (F_SCALE >= A_SCALE) ? (F_SCALE - A_SCALE) : (A_SCALE - F_SCALE);

   logic signed [IW-1:0] ax;
   assign ax = signed'({{(IW-A_WIDTH){a[A_WIDTH-1]}}, a});

   generate
      if (MODE == 0) begin : g_widen
         assign x = ax <<< SH;
      end else if (MODE == 1) begin : g_round
         localparam logic [IW-1:0] HALF = {{(IW-1){1'b0}}, 1'b1} << (SH - 1);
         logic signed [IW-1:0] xs;
         assign xs = (ax + signed'(HALF)) >>> SH;
         assign x  = xs;
      end else begin : g_floor
         logic signed [IW-1:0] xs;
         assign xs = ax >>> SH;
         assign x  = xs;
      end

      // In range exactly when every bit from the output sign bit upward agrees.
      if (IW > F_WIDTH) begin : g_chk
         logic [IW-F_WIDTH:0] top_bits;
         assign top_bits = x[IW-1:F_WIDTH-1];
         assign ovf = !((&top_bits) || !(|top_bits));
      end else begin : g_nochk
         assign ovf = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/norm_pipe.sv
// Two-stage registered normaliser with valid/ready backpressure, sideband pass-through,
// rounding/saturation options and a saturating overflow counter.
module norm_pipe
   import norm_pkg::*;
#(
   parameter int A_WIDTH    = 32,
   parameter int A_SCALE    = 12,
   parameter int F_WIDTH    = 32,
   parameter int F_SCALE    = 12,
   parameter int VALIDWIDTH = 1,
   parameter int PASSWIDTH  = 1,
   parameter int ROUND      = ROUND_HALF_UP,
   parameter int SAT        = SAT_CLAMP,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [VALIDWIDTH-1:0] a_valid,
   output logic                  a_ready,
   input  logic [A_WIDTH-1:0]    a,
   input  logic [PASSWIDTH-1:0]  a_pass,
   output logic [VALIDWIDTH-1:0] f_valid,
   input  logic                  f_ready,
   output logic [F_WIDTH-1:0]    f,
   output logic [PASSWIDTH-1:0]  f_pass,
   output logic                  f_ovf,
   output logic [CNT_WIDTH-1:0]  ovf_count,
   input  logic                  ovf_clear
);

   localparam int IW = norm_iw(A_WIDTH, A_SCALE, F_WIDTH, F_SCALE);
   localparam logic [F_WIDTH-1:0] F_MAX = {1'b0, {(F_WIDTH-1){1'b1}}};
   localparam logic [F_WIDTH-1:0] F_MIN = {1'b1, {(F_WIDTH-1){1'b0}}};

   logic [IW-1:0]         x_next;
   logic                  ovf_next;
   logic [VALIDWIDTH-1:0] s1_valid_reg;
   logic [IW-1:0]         s1_x_reg;
   logic                  s1_ovf_reg;
   logic [PASSWIDTH-1:0]  s1_pass_reg;
   logic                  s1_full, s2_full, en1, en2, f_xfer;
   logic [F_WIDTH-1:0]    f_next;
   logic                  unused_x;

   norm_round #(
      .A_WIDTH (A_WIDTH),
      .A_SCALE (A_SCALE),
      .F_WIDTH (F_WIDTH),
      .F_SCALE (F_SCALE),
      .ROUND   (ROUND),
      .IW      (IW)
   ) u_round (
      .a   (a),
      .x   (x_next),
      .ovf (ovf_next)
   );

   // A stage advances when the stage after it is free or draining this cycle.
   assign s1_full = |s1_valid_reg;
   assign s2_full = |f_valid;
   assign en2     = f_ready || !s2_full;
   assign en1     = en2 || !s1_full;
   assign a_ready = en1;
   assign f_xfer  = s2_full && f_ready;

   // Only the low bits and the sign of the intermediate reach the output mux.
   assign unused_x = ^s1_x_reg;

   always_comb begin
      f_next = s1_x_reg[F_WIDTH-1:0];
      if (SAT == SAT_CLAMP && s1_ovf_reg)
         f_next = s1_x_reg[IW-1] ? F_MIN : F_MAX;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg <= '0;
         s1_x_reg     <= '0;
         s1_ovf_reg   <= 1'b0;
         s1_pass_reg  <= '0;
      end else if (en1) begin
         s1_valid_reg <= a_valid;
         if (|a_valid) begin
            s1_x_reg    <= x_next;
            s1_ovf_reg  <= ovf_next;
            s1_pass_reg <= a_pass;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         f_valid <= '0;
         f       <= '0;
         f_pass  <= '0;
         f_ovf   <= 1'b0;
      end else if (en2) begin
         f_valid <= s1_valid_reg;
         if (s1_full) begin
            f      <= f_next;
            f_pass <= s1_pass_reg;
            f_ovf  <= s1_ovf_reg;
         end
      end
   end

   // Clear takes priority over the all-ones hold; a coincident overflow still counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_count <= '0;
      end else if (ovf_clear) begin
         ovf_count <= (f_xfer && f_ovf) ? CNT_WIDTH'(1) : '0;
      end else if (f_xfer && f_ovf && !(&ovf_count)) begin
         ovf_count <= ovf_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: doc/norm_pipe.md
# norm_pipe

Pipelined signed fixed-point normaliser with selectable rounding and saturation, valid/ready flow control, sideband pass-through and an overflow counter. It converts an A_WIDTH/A_SCALE sample to F_WIDTH/F_SCALE and sits between arithmetic blocks (MAC, dot-product, filter outputs) whose result format differs from the consumer's. It is the registered successor to the zero-latency normaliser: it adds rounding, clamping, overflow reporting and backpressure.

## Interface
- A_WIDTH, 32, input total width (signed two's complement)
- A_SCALE, 12, input fractional bits
- F_WIDTH, 32, output total width
- F_SCALE, 12, output fractional bits
- VALIDWIDTH, 1, width of valid vector carried with each sample
- PASSWIDTH, 1, width of opaque sideband carried with each sample
- ROUND, 1, 0 = truncate (floor), 1 = round half toward +inf
- SAT, 1, 0 = wrap (keep low F_WIDTH bits), 1 = clamp to F range
- CNT_WIDTH, 16, overflow counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- a_valid  in  VALIDWIDTH  sample present when any bit set; vector forwarded unchanged
- a_ready  out  1  input accepted when a_ready and |a_valid
- a  in  A_WIDTH  input sample
- a_pass  in  PASSWIDTH  sideband, forwarded unchanged
- f_valid  out  VALIDWIDTH  output valid vector
- f_ready  in  1  downstream accept
- f  out  F_WIDTH  normalised sample
- f_pass  out  PASSWIDTH  sideband aligned with f
- f_ovf  out  1  this output sample was out of F range
- ovf_count  out  CNT_WIDTH  saturating count of transferred overflowed samples
- ovf_clear  in  1  synchronous clear of ovf_count

## Operation
- Let d = F_SCALE − A_SCALE.
- d ≥ 0: x = a << d, sign-extended; exact, ROUND ignored.
- d < 0, k = −d: ROUND=0 → x = a >>> k (floor); ROUND=1 → x = (a + 2^(k−1)) >>> k, addition performed at A_WIDTH+1 bits so it never wraps.
- Range check: ovf = x > 2^(F_WIDTH−1)−1 or x < −2^(F_WIDTH−1).
- SAT=1: f = clamped value on ovf, else x. SAT=0: f = x[F_WIDTH−1:0]. f_ovf = ovf in both modes.
- Stage 1 registers x (full intermediate width), a_valid, a_pass; stage 2 registers f, f_ovf, f_valid, f_pass.
- ovf_count increments by 1 on each output transfer (|f_valid && f_ready) with f_ovf=1; holds at all-ones. ovf_clear wins over hold: clear alone → 0; clear with a qualifying transfer in the same cycle → 1.
- Samples with a_valid = 0 are never stored; no bubbles propagate.

## Timing
- Latency 2 cycles from accepted input to f_valid, with f_ready held high.
- Throughput 1 sample/cycle with f_ready high.
- en2 = f_ready || !s2_full; en1 = en2 || !s1_full; a_ready = en1 (combinational from f_ready; documented path).
- While f_ready low, outputs f, f_valid, f_pass, f_ovf hold stable; up to 2 samples buffered, then a_ready = 0.
- Order strictly preserved; no sample dropped or duplicated.
- Reset: f_valid = 0, f = 0, f_pass = 0, f_ovf = 0, ovf_count = 0, both stages empty; a_ready = 1 the cycle after reset deasserts. Reset mid-stream discards buffered samples.

## Structure
- Package norm_pkg: localparams ROUND_TRUNC=0, ROUND_HALF_UP=1, SAT_WRAP=0, SAT_CLAMP=1; function computing intermediate width.
- One combinational sub-module norm_round (shift + rounding add + range check) feeding stage registers; saturation mux and counter in norm_pipe.

## Test plan
Config A_WIDTH=16, A_SCALE=8, F_WIDTH=8, F_SCALE=4 unless noted.
- a=0x0118 (17.5 in F units): ROUND=1 → f=0x12; ROUND=0 → f=0x11; f_ovf=0; f_valid exactly 2 cycles after acceptance.
- a=0xFFE8 (−1.5): ROUND=1 → f=0xFF; ROUND=0 → f=0xFE.
- a=0x7FFF: SAT=1 → f=0x7F, f_ovf=1; SAT=0,ROUND=1 → f=0x00, f_ovf=1; SAT=0,ROUND=0 → f=0xFF; a=0x8000, SAT=1 → f=0x80.
- Widening (F_WIDTH=24, F_SCALE=12): a=0xFF80 → f=0xFFF800, f_ovf=0.
- f_ready low 5 cycles, 4 back-to-back inputs with a_pass 1..4: two accepted, a_ready=0 until release; outputs then emerge in order 1,2,3,4 with matching f_pass.
- CNT_WIDTH=2: 5 overflowing transfers → ovf_count=3 (held); ovf_clear coincident with a 6th overflowing transfer → 1; ovf_clear alone → 0.
